// File: rtl/puf_pkg.sv
// Shared types for the PUF challenge sequencer.
// Holds the controller state enum and the command op codes.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    CAPTURE,
    DONE
  } puf_auth_state_t;

  localparam logic OP_ENROLL = 1'b0;
  localparam logic OP_VERIFY = 1'b1;

endpackage

// File: rtl/puf_hamming.sv
// Popcount of a XOR b, i.e. Hamming distance of two vectors.
// Ports: a, b (N_BITS) in; hd ($clog2(N_BITS+1)) out.
module puf_hamming #(
  parameter int N_BITS = 8,
  parameter int W      = $clog2(N_BITS + 1)
) (
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  output logic [W-1:0]      hd
);

  always_comb begin
    hd = '0;
    for (int i = 0; i < N_BITS; i++) begin
      hd = hd + W'(a[i] ^ b[i]);
    end
  end

endmodule

// File: rtl/puf_auth_ctrl.sv
// PUF challenge sequencer: enroll stores responses, verify sums HD.
// Ports: cmd_* host side, puf_* array side, res_*/enrolled result.
module puf_auth_ctrl
  import puf_pkg::*;
#(
  parameter int N_BITS  = 8,
  parameter int N_CHAL  = 4,
  parameter int HD_MAX  = 3,
  parameter int TIMEOUT = 1023,
  parameter int HD_W    = $clog2(N_BITS * N_CHAL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [N_BITS-1:0] cmd_chal,
  output logic [N_BITS-1:0] puf_chal,
  output logic              puf_clr,
  output logic              puf_en,
  input  logic [N_BITS-1:0] puf_resp,
  input  logic [N_BITS-1:0] puf_finish,
  output logic              res_valid,
  output logic              res_pass,
  output logic              res_err,
  output logic [HD_W-1:0]   res_hd,
  output logic              enrolled
);

  localparam int IDX_W = (N_CHAL > 1) ? $clog2(N_CHAL) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int PC_W  = $clog2(N_BITS + 1);

  puf_auth_state_t state;
  puf_auth_state_t state_nxt;

  logic              op_q;
  logic [IDX_W-1:0]  idx;
  logic [TO_W-1:0]   tcnt;
  logic [HD_W-1:0]   hd_acc;
  logic [HD_W-1:0]   hd_sum;
  logic [PC_W-1:0]   pc;
  logic [N_BITS-1:0] ref_tbl [N_CHAL];

  logic no_ref;
  logic fin;
  logic tmo;
  logic last;

  puf_hamming #(
    .N_BITS(N_BITS)
  ) u_ham (
    .a (puf_resp),
    .b (ref_tbl[idx]),
    .hd(pc)
  );

  assign no_ref = (cmd_op == OP_VERIFY) && !enrolled;
  assign fin    = &puf_finish;
  // tcnt counts completed RUN cycles, so this is the last allowed one
  assign tmo    = (tcnt == TO_W'(TIMEOUT - 1));
  assign last   = (idx == IDX_W'(N_CHAL - 1));
  // enroll never accumulates distance; hd_acc stays 0
  assign hd_sum = hd_acc
                + ((op_q == OP_VERIFY) ? HD_W'(pc) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    puf_clr   = 1'b0;
    puf_en    = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = no_ref ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        puf_clr   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        puf_en = 1'b1;
        if (fin) begin
          state_nxt = CAPTURE;
        end else if (tmo) begin
          state_nxt = DONE;
        end
      end
      CAPTURE: begin
        state_nxt = last ? DONE : CLEAR;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Results are loaded on entry to DONE so they are
  // valid in the same cycle as the res_valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_ENROLL;
      idx       <= '0;
      tcnt      <= '0;
      hd_acc    <= '0;
      puf_chal  <= '0;
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
      res_err   <= 1'b0;
      res_hd    <= '0;
      enrolled  <= 1'b0;
      for (int i = 0; i < N_CHAL; i++) begin
        ref_tbl[i] <= '0;
      end
    end else begin
      res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            idx    <= '0;
            hd_acc <= '0;
            if (no_ref) begin
              res_valid <= 1'b1;
              res_err   <= 1'b1;
              res_pass  <= 1'b0;
              res_hd    <= '0;
            end else begin
              puf_chal <= cmd_chal;
            end
          end
        end
        CLEAR: begin
          tcnt <= '0;
        end
        RUN: begin
          tcnt <= tcnt + TO_W'(1);
          if (!fin && tmo) begin
            res_valid <= 1'b1;
            res_err   <= 1'b1;
            res_pass  <= 1'b0;
            res_hd    <= hd_acc;
            // a partial table must not be trusted
            if (op_q == OP_ENROLL) begin
              enrolled <= 1'b0;
            end
          end
        end
        CAPTURE: begin
          if (op_q == OP_ENROLL) begin
            ref_tbl[idx] <= puf_resp;
          end
          hd_acc <= hd_sum;
          if (last) begin
            res_valid <= 1'b1;
            res_err   <= 1'b0;
            res_hd    <= hd_sum;
            res_pass  <= (op_q == OP_ENROLL)
                      || (hd_sum <= HD_W'(HD_MAX));
            if (op_q == OP_ENROLL) begin
              enrolled <= 1'b1;
            end
          end else begin
            idx      <= idx + IDX_W'(1);
            // chal = base + idx, wrapping modulo 2^N_BITS
            puf_chal <= puf_chal + N_BITS'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_auth_ctrl.sv
// Randomized self-checking bench for puf_auth_ctrl.
// Bench plays the PUF array and keeps a behavioural model.
module tb_puf_auth_ctrl;
  import puf_pkg::*;

  localparam int NC = 4;
  localparam int HDM = 3;
  localparam int TO = 1023;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [7:0] cmd_chal = '0;
  logic [7:0] puf_chal;
  logic       puf_clr;
  logic       puf_en;
  logic [7:0] puf_resp = '0;
  logic [7:0] puf_finish = '0;
  logic       res_valid;
  logic       res_pass;
  logic       res_err;
  logic [5:0] res_hd;
  logic       enrolled;

  puf_auth_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_chal  (cmd_chal),
    .puf_chal  (puf_chal),
    .puf_clr   (puf_clr),
    .puf_en    (puf_en),
    .puf_resp  (puf_resp),
    .puf_finish(puf_finish),
    .res_valid (res_valid),
    .res_pass  (res_pass),
    .res_err   (res_err),
    .res_hd    (res_hd),
    .enrolled  (enrolled)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  // PUF array model
  logic [7:0] cur_base = '0;
  int         cur_k = 1;
  bit         cur_stuck = 0;
  logic [7:0] resp_q [4];
  int         rc = 0;
  int         en_cycles = 0;
  logic [7:0] clr_q [$];

  always @(negedge clk) begin
    logic [7:0] d;
    d = puf_chal - cur_base;
    puf_resp = resp_q[d[1:0]];
    if (puf_clr === 1'b1) clr_q.push_back(puf_chal);
    if (puf_en === 1'b1) begin
      en_cycles++;
      rc++;
      if (cur_stuck) puf_finish = 8'h7F;
      else if (rc == cur_k) puf_finish = 8'hFF;
      else puf_finish = 8'($urandom) & 8'h7F;
    end else begin
      rc = 0;
      puf_finish = '0;
    end
  end

  // reference model
  bit         m_enr = 0;
  logic [7:0] m_tbl [4];

  task automatic do_op(input string tag, input logic op,
                       input logic [7:0] base, input int k,
                       input bit stuck, input bit hold);
    int   e_lat, lat, e_hd, e_steps;
    bit   e_err, e_pass, e_enr;
    logic [7:0] ec;
    e_hd = 0;
    e_enr = m_enr;
    if (op == OP_VERIFY && !m_enr) begin
      e_lat = 1; e_err = 1; e_pass = 0; e_steps = 0;
    end else if (stuck) begin
      e_lat = TO + 2; e_err = 1; e_pass = 0; e_steps = 1;
      if (op == OP_ENROLL) e_enr = 0;
    end else begin
      e_lat = NC * (k + 2) + 1; e_err = 0; e_steps = NC;
      if (op == OP_VERIFY) begin
        for (int i = 0; i < NC; i++)
          e_hd += $countones(resp_q[i] ^ m_tbl[i]);
        e_pass = (e_hd <= HDM);
      end else begin
        e_pass = 1; e_enr = 1;
      end
    end
    cur_base = base; cur_k = k; cur_stuck = stuck;
    clr_q.delete();
    @(negedge clk);
    cmd_valid = 1; cmd_op = op; cmd_chal = base;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 0;
    lat = 0;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        lat = n + 1;
        break;
      end
    end
    cmd_valid = 0;
    check({tag, ":lat"}, lat, e_lat);
    check({tag, ":err"}, res_err, e_err);
    check({tag, ":pass"}, res_pass, e_pass);
    check({tag, ":hd"}, res_hd, e_hd);
    check({tag, ":enr"}, enrolled, e_enr);
    check({tag, ":busy"}, cmd_ready, 0);
    check({tag, ":nclr"}, clr_q.size(), e_steps);
    for (int i = 0; i < e_steps && i < clr_q.size(); i++) begin
      ec = base + 8'(i);
      check({tag, ":chal"}, clr_q[i], ec);
    end
    @(negedge clk);
    check({tag, ":strobe"}, res_valid, 0);
    check({tag, ":rdy"}, cmd_ready, 1);
    check({tag, ":hold"}, res_hd, e_hd);
    m_enr = e_enr;
    if (op == OP_ENROLL && !stuck)
      for (int i = 0; i < NC; i++) m_tbl[i] = resp_q[i];
  endtask

  task automatic set_resp(input logic [7:0] a, b, c, d);
    resp_q[0] = a; resp_q[1] = b;
    resp_q[2] = c; resp_q[3] = d;
  endtask

  int en0, seen;
  logic op_r;

  initial begin
    for (int i = 0; i < NC; i++) begin
      resp_q[i] = '0;
      m_tbl[i] = '0;
    end
    // reset state
    #3;
    check("rst:outs",
          {puf_chal, puf_clr, puf_en, res_valid,
           res_pass, res_err, res_hd, enrolled}, 0);
    check("rst:rdy", cmd_ready, 1);
    #9 rst_n = 1;
    @(negedge clk);
    check("rst:rdy2", cmd_ready, 1);
    check("rst:enr", enrolled, 0);

    // verify before enroll
    en0 = en_cycles;
    do_op("vnoref", OP_VERIFY, 8'h33, 5, 0, 0);
    check("vnoref:en", en_cycles, en0);

    // enroll with wrap
    set_resp(8'hA5, 8'h3C, 8'h0F, 8'hF0);
    do_op("enr", OP_ENROLL, 8'hFE, 10, 0, 0);
    // verify thresholds
    do_op("v0", OP_VERIFY, 8'h40, 3, 0, 0);
    set_resp(8'hA4, 8'h3D, 8'h0E, 8'hF0);
    do_op("v3", OP_VERIFY, 8'h41, 4, 0, 0);
    check("v3:hd3", res_hd, 3);
    set_resp(8'hA4, 8'h3D, 8'h0E, 8'hF1);
    do_op("v4", OP_VERIFY, 8'h42, 2, 0, 0);
    check("v4:fail", res_pass, 0);

    // randomized ops
    for (int t = 0; t < 12; t++) begin
      op_r = 1'($urandom_range(0, 1));
      for (int i = 0; i < NC; i++) begin
        if (op_r == OP_ENROLL) resp_q[i] = 8'($urandom);
        else resp_q[i] = m_tbl[i] ^ (8'($urandom)
                          & 8'($urandom) & 8'($urandom));
      end
      do_op("rnd", op_r, 8'($urandom),
            $urandom_range(1, 8), 0, 0);
    end

    // timeout during enroll clears enrolled
    set_resp(8'h11, 8'h22, 8'h33, 8'h44);
    do_op("enr2", OP_ENROLL, 8'h10, 3, 0, 0);
    do_op("tmo", OP_ENROLL, 8'h20, 5, 1, 0);
    // finish exactly on the last allowed cycle
    do_op("tlast", OP_ENROLL, 8'h30, TO, 0, 0);

    // mid-cycle reset pulse
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("rst2:outs",
          {puf_chal, puf_clr, puf_en, res_valid,
           res_pass, res_err, res_hd, enrolled}, 0);
    #5 rst_n = 1;
    @(negedge clk);
    check("rst2:rdy", cmd_ready, 1);
    check("rst2:enr", enrolled, 0);
    m_enr = 0;
    for (int i = 0; i < NC; i++) m_tbl[i] = '0;

    // cmd_valid held while busy
    set_resp(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    do_op("busy", OP_ENROLL, 8'hC0, 6, 0, 1);
    do_op("busyv", OP_VERIFY, 8'hC8, 2, 0, 1);

    // reset abort in RUN
    cur_k = 40; cur_stuck = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_op = OP_ENROLL; cmd_chal = 8'h01;
    @(posedge clk);
    #1 cmd_valid = 0;
    for (int n = 0; n < 20 && puf_en !== 1'b1; n++)
      @(negedge clk);
    check("abort:run", puf_en, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("abort:en", puf_en, 0);
    check("abort:rdy", cmd_ready, 1);
    #4 rst_n = 1;
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (res_valid === 1'b1) seen++;
    end
    check("abort:nores", seen, 0);
    check("abort:enr", enrolled, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
